mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter that answers the CPU's data-memory bus (address, write enable, write data, read data).
- The CPU top-level decodes `hit` and muxes `read_data` into the load path ahead of data memory.
- Stored bytes go into a FIFO and are serialized as 8N1 frames, LSB first, on `tx`.
- Loads return status and configuration combinationally, within the same cycle, as a single-cycle core requires.

---
 rtl/mmio_uart_tx.sv | 198 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for a single-cycle core: FIFO-buffered
// stores to TXDATA are serialized LSB first on tx; loads return status combinationally.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] BAUD_RESET = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        mem_write,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        tx,
  output logic        tx_idle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // A zero divisor would stall the baud counter, so it is promoted to 1.
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic             overflow;
  logic [15:0]      bauddiv;
  logic [15:0]      frame_div;
  logic [15:0]      baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  logic [1:0]       offset;
  logic             bus_wr;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             full;
  logic             empty;
  logic             bit_end;
  logic             go_idle;
  logic             busy;
  logic [7:0]       count_ext;
  logic             unused_bits;

  assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset    = addr[3:2];
  assign bus_wr    = mem_write && hit;
  assign push_req  = bus_wr && (offset == 2'd0);
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign busy      = (state != S_IDLE);
  assign bit_end   = (baud_cnt == frame_div - 16'd1);
  assign count_ext = 8'(count);

  // The FSM takes the head byte whenever it is ready for a new frame.
  assign pop     = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
  assign go_idle = empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
  assign push_ok = push_req && (!full || pop);

  assign unused_bits = ^{addr[1:0], write_data[31:16]};

  always_comb begin
    count_n = count;
    if (push_ok && !pop) begin
      count_n = count + CNT_W'(1);
    end else if (!push_ok && pop) begin
      count_n = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= write_data[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      bauddiv  <= clamp_div(BAUD_RESET);
      tx_idle  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_n;
      // A dropped byte outranks a simultaneous clear so the loss is never hidden.
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end else if (bus_wr && (offset == 2'd1) && write_data[3]) begin
        overflow <= 1'b0;
      end
      if (bus_wr && (offset == 2'd2)) begin
        bauddiv <= clamp_div(write_data[15:0]);
      end
      tx_idle <= go_idle && (count_n == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      tx        <= 1'b1;
      shift     <= 8'd0;
      bit_idx   <= 3'd0;
      baud_cnt  <= 16'd0;
      frame_div <= clamp_div(BAUD_RESET);
    end else begin
      case (state)
        S_IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= 16'd0;
          if (!empty) begin
            shift     <= mem[rd_ptr];
            frame_div <= bauddiv;
            state     <= S_START;
            tx        <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            state    <= S_DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            // Chain straight into the next start bit when more data is queued.
            if (!empty) begin
              shift     <= mem[rd_ptr];
              frame_div <= bauddiv;
              state     <= S_START;
              tx        <= 1'b0;
            end else begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    read_data = 32'd0;
    if (hit) begin
      case (offset)
        2'd1:    read_data = {16'd0, count_ext, 4'd0, overflow, busy, empty, full};
        2'd2:    read_data = {16'd0, bauddiv};
        default: read_data = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: bus tasks drive stores/loads, a serial monitor
// decodes every frame on tx against a scoreboard of expected bytes and divisors.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_TX = BASE;
  localparam logic [31:0] A_ST = BASE + 32'd4;
  localparam logic [31:0] A_BD = BASE + 32'd8;
  localparam logic [31:0] A_RS = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr = 32'd0;
  logic        mem_write = 1'b0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        hit;
  logic        tx;
  logic        tx_idle;

  mmio_uart_tx #(
    .BASE_ADDR(BASE),
    .FIFO_DEPTH(8),
    .BAUD_RESET(16'd16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .mem_write(mem_write),
    .write_data(write_data),
    .read_data(read_data),
    .hit(hit),
    .tx(tx),
    .tx_idle(tx_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;

  frame_t sb[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     cyc = 0;
  logic   mon_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Serial monitor: every start bit pops one expected frame and checks each cycle.
  initial begin
    frame_t     ef;
    int         errs;
    logic [7:0] rx;
    bit         aborted;
    int         bi;
    logic       lvl;
    int         hold;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame: tx low at cycle %0d, required no frame", cyc);
          hold = 0;
          while (tx === 1'b0 && hold < 5000) begin
            @(negedge clk);
            hold++;
          end
        end else begin
          ef = sb.pop_front();
          mon_busy = 1'b1;
          errs = 0;
          rx = 8'd0;
          aborted = 1'b0;
          for (int k = 0; k < 10 * ef.div; k++) begin
            if (k > 0) @(negedge clk);
            if (reset !== 1'b0) begin
              aborted = 1'b1;
              break;
            end
            bi = k / ef.div;
            if (bi == 0) lvl = 1'b0;
            else if (bi == 9) lvl = 1'b1;
            else lvl = ef.data[bi-1];
            if (tx !== lvl) errs++;
            if (bi >= 1 && bi <= 8 && (k % ef.div) == ef.div / 2) rx[bi-1] = tx;
          end
          if (!aborted) begin
            vectors++;
            if (rx !== ef.data) begin
              miscompares++;
              $display("FAIL frame_data: got 0x%02h, required 0x%02h", rx, ef.data);
            end
            vectors++;
            if (errs != 0) begin
              miscompares++;
              $display("FAIL frame_timing: %0d cycles wrong in frame 0x%02h div %0d, required 0",
                       errs, ef.data, ef.div);
            end
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    write_data = d;
    mem_write = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
    @(negedge clk);
    mem_write = 1'b0;
    addr = a;
    #1;
    d = read_data;
    h = hit;
  endtask

  task automatic wait_done(input int limit);
    int waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(tx_idle === 1'b1 && !mon_busy && sb.size() == 0) && waited < limit);
    vectors++;
    if (!(tx_idle === 1'b1 && !mon_busy && sb.size() == 0)) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d frames pending after %0d cycles, required 0",
               sb.size(), waited);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        h;
    bus_read(A_ST, d, h);
    vectors++;
    if (d !== 32'h0000_0002) begin
      miscompares++;
      $display("FAIL reset_status: got 0x%08h, required 0x00000002", d);
    end
    vectors++;
    if (h !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_hit: got %b, required 1", h);
    end
    bus_read(A_BD, d, h);
    vectors++;
    if (d !== 32'd16) begin
      miscompares++;
      $display("FAIL reset_bauddiv: got %0d, required 16", d);
    end
    vectors++;
    if (tx !== 1'b1 || tx_idle !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_line: tx=%b tx_idle=%b, required 1 1", tx, tx_idle);
    end
  endtask

  task automatic test_single_frame();
    int n;
    bus_write(A_BD, 32'd4);
    bus_write(A_TX, 32'h0000_00A5);
    sb.push_back(frame_t'{8'hA5, 4});
    @(negedge clk);
    vectors++;
    if (tx !== 1'b1) begin
      miscompares++;
      $display("FAIL start_latency_early: tx=%b after store edge, required 1", tx);
    end
    @(negedge clk);
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++;
      $display("FAIL start_latency: tx=%b one edge after store, required 0", tx);
    end
    n = 1;
    while (tx_idle !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n != 41) begin
      miscompares++;
      $display("FAIL idle_latency: tx_idle after %0d edges, required 41", n);
    end
    wait_done(100);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        h;
    logic [7:0]  b;
    int          t1;
    int          n;
    bus_write(A_BD, 32'd2);
    t1 = 0;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      bus_write(A_TX, {24'hABCDEF, b});
      if (i == 0) t1 = cyc;
      if (i < 9) sb.push_back(frame_t'{b, 2});
      if (i == 8) begin
        addr = A_ST;
        #1;
        vectors++;
        if (read_data !== 32'h0000_0805) begin
          miscompares++;
          $display("FAIL nine_accepted_status: got 0x%08h, required 0x00000805", read_data);
        end
      end
    end
    bus_read(A_ST, d, h);
    vectors++;
    if (d !== 32'h0000_080D) begin
      miscompares++;
      $display("FAIL overflow_status: got 0x%08h, required 0x0000080D", d);
    end
    bus_write(A_ST, 32'h0000_0008);
    bus_read(A_ST, d, h);
    vectors++;
    if (d !== 32'h0000_0805) begin
      miscompares++;
      $display("FAIL overflow_clear: got 0x%08h, required 0x00000805", d);
    end
    n = 0;
    while (tx_idle !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (cyc - t1 != 181) begin
      miscompares++;
      $display("FAIL b2b_duration: idle %0d edges after first store, required 181", cyc - t1);
    end
    wait_done(100);
    bus_read(A_ST, d, h);
    vectors++;
    if (d !== 32'h0000_0002) begin
      miscompares++;
      $display("FAIL b2b_final_status: got 0x%08h, required 0x00000002", d);
    end
  endtask

  task automatic test_baud_change();
    logic [31:0] d;
    logic        h;
    int          t1;
    int          n;
    bus_write(A_BD, 32'd4);
    bus_write(A_TX, 32'h0000_005A);
    t1 = cyc;
    sb.push_back(frame_t'{8'h5A, 4});
    bus_write(A_TX, 32'h0000_00C3);
    sb.push_back(frame_t'{8'hC3, 8});
    repeat (10) @(negedge clk);
    bus_write(A_BD, 32'd8);
    bus_read(A_BD, d, h);
    vectors++;
    if (d !== 32'd8) begin
      miscompares++;
      $display("FAIL baud_readback: got %0d, required 8", d);
    end
    n = 0;
    while (tx_idle !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (cyc - t1 != 121) begin
      miscompares++;
      $display("FAIL baud_change_duration: idle %0d edges after store, required 121", cyc - t1);
    end
    wait_done(100);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    logic        h;
    int          lows;
    bus_write(A_BD, 32'd4);
    bus_write(A_TX, 32'h0000_0011);
    sb.push_back(frame_t'{8'h11, 4});
    bus_write(A_TX, 32'h0000_0022);
    sb.push_back(frame_t'{8'h22, 4});
    bus_write(A_TX, 32'h0000_0033);
    sb.push_back(frame_t'{8'h33, 4});
    repeat (12) @(posedge clk);
    #1;
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_data_bit: tx=%b before reset, required 0", tx);
    end
    #1;
    reset = 1'b1;
    #1;
    vectors++;
    if (tx !== 1'b1 || tx_idle !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset_line: tx=%b tx_idle=%b, required 1 1", tx, tx_idle);
    end
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus_read(A_ST, d, h);
    vectors++;
    if (d !== 32'h0000_0002) begin
      miscompares++;
      $display("FAIL post_reset_status: got 0x%08h, required 0x00000002", d);
    end
    bus_read(A_BD, d, h);
    vectors++;
    if (d !== 32'd16) begin
      miscompares++;
      $display("FAIL post_reset_bauddiv: got %0d, required 16", d);
    end
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    vectors++;
    if (lows != 0) begin
      miscompares++;
      $display("FAIL discarded_bytes: tx low for %0d cycles, required 0", lows);
    end
  endtask

  task automatic test_div_zero_and_decode();
    logic [31:0] d;
    logic        h;
    int          n;
    bus_write(A_BD, 32'h0000_0000);
    bus_read(A_BD, d, h);
    vectors++;
    if (d !== 32'd1) begin
      miscompares++;
      $display("FAIL div_zero_readback: got %0d, required 1", d);
    end
    bus_write(A_TX, 32'h0000_003C);
    sb.push_back(frame_t'{8'h3C, 1});
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++;
      $display("FAIL div1_start: tx=%b one edge after store, required 0", tx);
    end
    n = 1;
    while (tx_idle !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n != 11) begin
      miscompares++;
      $display("FAIL div1_duration: tx_idle after %0d edges, required 11", n);
    end
    wait_done(50);
    bus_read(A_RS, d, h);
    vectors++;
    if (d !== 32'd0 || h !== 1'b1) begin
      miscompares++;
      $display("FAIL reserved_read: data 0x%08h hit %b, required 0x00000000 1", d, h);
    end
    bus_write(A_RS, 32'hFFFF_FFFF);
    bus_read(A_BD, d, h);
    vectors++;
    if (d !== 32'd1) begin
      miscompares++;
      $display("FAIL reserved_write_bauddiv: got %0d, required 1", d);
    end
    bus_read(A_ST + 32'd3, d, h);
    vectors++;
    if (d !== 32'h0000_0002) begin
      miscompares++;
      $display("FAIL byte_offset_ignored: got 0x%08h, required 0x00000002", d);
    end
    bus_read(32'h1000_0008, d, h);
    vectors++;
    if (d !== 32'd0 || h !== 1'b0) begin
      miscompares++;
      $display("FAIL outside_read: data 0x%08h hit %b, required 0x00000000 0", d, h);
    end
    bus_write(32'h1000_0000, 32'h0000_0055);
    bus_write(BASE + 32'h10, 32'h0000_0055);
    bus_write(32'h1000_0008, 32'h0000_0007);
    repeat (30) @(negedge clk);
    bus_read(A_ST, d, h);
    vectors++;
    if (d !== 32'h0000_0002) begin
      miscompares++;
      $display("FAIL outside_write_status: got 0x%08h, required 0x00000002", d);
    end
    bus_read(A_BD, d, h);
    vectors++;
    if (d !== 32'd1) begin
      miscompares++;
      $display("FAIL outside_write_bauddiv: got %0d, required 1", d);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_baud_change();
    test_reset_midframe();
    test_div_zero_and_decode();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
